// File: rtl/unsigned_seq_divider_16by8_if.sv
// rtl/unsigned_seq_divider_16by8_if.sv - operand/result handshake bundle for the 16/8 divider
interface unsigned_seq_divider_16by8_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] z;
    logic [7:0]  y;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  x;
    logic [7:0]  r;
    logic        div_by_zero;
    logic        overflow;

    modport master (
        output in_valid, z, y, out_ready,
        input  in_ready, out_valid, x, r, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, z, y, out_ready,
        output in_ready, out_valid, x, r, div_by_zero, overflow
    );
endinterface

// File: rtl/unsigned_seq_divider_16by8.sv
// rtl/unsigned_seq_divider_16by8.sv - sequential restoring 16/8 unsigned divider, one quotient bit per cycle
module unsigned_seq_divider_16by8 #(
    parameter int APPROX_L = 0
) (
    input  logic clk,
    input  logic rst,
    unsigned_seq_divider_16by8_if.slave bus
);
    // Last iteration index and the mask that zeroes the skipped low quotient bits.
    localparam logic [2:0] LAST_I    = 3'(APPROX_L);
    localparam logic [7:0] KEEP_MASK = 8'hFF << APPROX_L;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [8:0] p;        // partial remainder, always < y between iterations
    logic [7:0] d;        // low dividend bits still to be shifted in
    logic [7:0] q;        // quotient bits built MSB first
    logic [2:0] i;        // current quotient bit index
    logic [7:0] y_q;      // latched divisor

    logic [8:0] t;
    logic       t_ge;
    logic [8:0] p_next;
    logic [7:0] q_next;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        t         = {p[7:0], d[i]};
        t_ge      = (t >= {1'b0, y_q});
        p_next    = t_ge ? (t - {1'b0, y_q}) : t;
        q_next    = q;
        q_next[i] = t_ge;
    end

    assign bus.in_ready = (state == IDLE);

    // Control FSM with registered result and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bus.out_valid   <= 1'b0;
            bus.x           <= 8'h00;
            bus.r           <= 8'h00;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            p               <= 9'h000;
            d               <= 8'h00;
            q               <= 8'h00;
            i               <= 3'd0;
            y_q             <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        y_q <= bus.y;
                        if (bus.y == 8'h00) begin
                            bus.x           <= 8'hFF;
                            bus.r           <= 8'hFF;
                            bus.div_by_zero <= 1'b1;
                            bus.out_valid   <= 1'b1;
                            state           <= DONE;
                        end else if (bus.z[15:8] >= bus.y) begin
                            // Quotient would need more than 8 bits.
                            bus.x         <= 8'hFF;
                            bus.r         <= 8'hFF;
                            bus.overflow  <= 1'b1;
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            p     <= {1'b0, bus.z[15:8]};
                            d     <= bus.z[7:0];
                            q     <= 8'h00;
                            i     <= 3'd7;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    p <= p_next;
                    q <= q_next;
                    if (i == LAST_I) begin
                        // Remainder is only meaningful when every quotient bit was computed.
                        bus.x         <= q_next & KEEP_MASK;
                        bus.r         <= (APPROX_L == 0) ? p_next[7:0] : 8'h00;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        i <= i - 3'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid   <= 1'b0;
                        bus.div_by_zero <= 1'b0;
                        bus.overflow    <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unsigned_seq_divider_16by8.sv
// tb/tb_unsigned_seq_divider_16by8.sv - scoreboard bench for exact and truncated divider instances
module tb_unsigned_seq_divider_16by8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unsigned_seq_divider_16by8_if if0();
    unsigned_seq_divider_16by8_if if2();

    unsigned_seq_divider_16by8 #(.APPROX_L(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    unsigned_seq_divider_16by8 #(.APPROX_L(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] r;
        logic       dz;
        logic       ov;
    } res_t;

    res_t exp0[$];
    res_t exp2[$];
    int   checks = 0;
    int   failures = 0;
    bit   rand_ready = 1'b0;

    // Reference: plain integer division, error predicates, and truncation of the low l quotient bits.
    function automatic res_t model(input logic [15:0] zz, input logic [7:0] yy, input int l);
        res_t m;
        int   qq;
        int   rr;
        m = '0;
        if (yy == 8'h00) begin
            m.x = 8'hFF; m.r = 8'hFF; m.dz = 1'b1;
        end else if (int'(zz) >= int'(yy) * 256) begin
            m.x = 8'hFF; m.r = 8'hFF; m.ov = 1'b1;
        end else begin
            qq  = int'(zz) / int'(yy);
            rr  = int'(zz) % int'(yy);
            m.x = 8'(qq) & (8'hFF << l);
            m.r = (l == 0) ? 8'(rr) : 8'h00;
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop the oldest expectation on every result handshake.
    always @(negedge clk) begin
        res_t e;
        if (!rst && if0.out_valid && if0.out_ready) begin
            if (exp0.size() == 0) begin
                checks++; failures++;
                $display("FAIL mon0_unexpected actual=result required=none");
            end else begin
                e = exp0.pop_front();
                check("mon0_result", {if0.x, if0.r, if0.div_by_zero, if0.overflow}, e);
            end
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (!rst && if2.out_valid && if2.out_ready) begin
            if (exp2.size() == 0) begin
                checks++; failures++;
                $display("FAIL mon2_unexpected actual=result required=none");
            end else begin
                e = exp2.pop_front();
                check("mon2_result", {if2.x, if2.r, if2.div_by_zero, if2.overflow}, e);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) begin
                if0.out_ready = ($urandom_range(0, 3) != 0);
                if2.out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Present operands until accepted; returns right after the accept edge.
    task automatic issue(input bit sel, input logic [15:0] zz, input logic [7:0] yy);
        bit ok;
        ok = 1'b0;
        if (sel) begin if2.in_valid = 1'b1; if2.z = zz; if2.y = yy; end
        else     begin if0.in_valid = 1'b1; if0.z = zz; if0.y = yy; end
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sel ? if2.in_ready : if0.in_ready) begin ok = 1'b1; break; end
        end
        if (ok) begin
            if (sel) exp2.push_back(model(zz, yy, 2));
            else     exp0.push_back(model(zz, yy, 0));
        end else begin
            checks++; failures++;
            $display("FAIL issue_timeout actual=in_ready_0 required=in_ready_1");
        end
        @(posedge clk); #1;
        if (sel) begin if2.in_valid = 1'b0; if2.z = 16'($urandom); if2.y = 8'($urandom); end
        else     begin if0.in_valid = 1'b0; if0.z = 16'($urandom); if0.y = 8'($urandom); end
    endtask

    task automatic wait_valid(input bit sel, input int want, input string name);
        int k;
        k = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (sel ? if2.out_valid : if0.out_valid) begin k = n; break; end
        end
        check(name, k, want);
    endtask

    task automatic release_out(input bit sel);
        if (sel) if2.out_ready = 1'b1; else if0.out_ready = 1'b1;
        @(posedge clk); #1;
        if (sel) if2.out_ready = 1'b0; else if0.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] zz;
        logic [7:0]  yy;
        bit          seen;
        if0.in_valid = 1'b0; if0.out_ready = 1'b0; if0.z = 16'h0; if0.y = 8'h0;
        if2.in_valid = 1'b0; if2.out_ready = 1'b0; if2.z = 16'h0; if2.y = 8'h0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", if0.out_valid, 0);
        check("rst_x_r", {if0.x, if0.r}, 0);
        check("rst_flags", {if0.div_by_zero, if0.overflow}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", {if0.in_ready, if2.in_ready}, 2'b11);

        // Exact quotient, no remainder.
        issue(0, 16'h159F, 8'd45);
        wait_valid(0, 8, "lat_exact");
        release_out(0);
        check("in_ready_after_hs", if0.in_ready, 1);
        check("out_valid_after_hs", if0.out_valid, 0);

        // Result must hold under backpressure while new operands are ignored.
        issue(0, 16'd5540, 8'd45);
        wait_valid(0, 8, "lat_exact2");
        for (int c = 0; c < 5; c++) begin
            if0.in_valid = 1'b1; if0.z = 16'($urandom); if0.y = 8'($urandom);
            @(posedge clk); #1;
            check("hold_x_r", {if0.x, if0.r}, {8'd123, 8'd5});
            check("hold_ready_valid", {if0.in_ready, if0.out_valid}, 2'b01);
        end
        if0.in_valid = 1'b0;
        release_out(0);
        check("hold_in_ready_after", if0.in_ready, 1);
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (if0.out_valid) seen = 1'b1; end
        check("hold_no_stray_op", seen, 0);

        // Error paths complete in one edge.
        issue(0, 16'h1234, 8'h00);
        wait_valid(0, 1, "lat_div_by_zero");
        release_out(0);
        issue(0, 16'h2D00, 8'h2D);
        wait_valid(0, 1, "lat_overflow");
        release_out(0);

        // Truncated instance: two low quotient bits skipped.
        issue(1, 16'd5540, 8'd45);
        wait_valid(1, 6, "lat_approx2");
        release_out(1);

        // Abort mid-run.
        issue(0, 16'd5540, 8'd45);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp0.pop_back());
        check("abort_state", {if0.in_ready, if0.out_valid}, 2'b10);
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (if0.out_valid) seen = 1'b1; end
        check("abort_no_result", seen, 0);
        issue(0, 16'd65025, 8'd255);
        wait_valid(0, 8, "lat_max");
        release_out(0);

        // Random sweep with random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 2800; n++) begin
            yy = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            zz = 16'($urandom);
            if (yy != 8'h00 && $urandom_range(0, 3) != 0) zz[15:8] = 8'($urandom_range(0, int'(yy) - 1));
            issue(n % 8 == 7, zz, yy);
        end
        for (int n = 0; n < 200; n++) begin
            if (exp0.size() == 0 && exp2.size() == 0) break;
            @(posedge clk);
        end
        rand_ready = 1'b0;
        check("drain_queues", exp0.size() + exp2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
